// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_word_packer
//  Purpose  : Pops UART RX FIFO bytes and packs N_BYTES of them into one
//             little-endian word presented on a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_word_packer #(
    parameter int B       = 8,
    parameter int N_BYTES = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [B-1:0]         fifo_r_data,
    output logic                 fifo_rd,
    input  logic                 flush,
    output logic [B*N_BYTES-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 timeout_err
);

    localparam int c_cnt_w  = $clog2(N_BYTES);
    localparam int c_idle_w = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0]  c_last_byte = c_cnt_w'(N_BYTES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idle_w-1:0] c_idle_last = (TIMEOUT == 0) ? '0 : c_idle_w'(TIMEOUT - 1);
    localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_OUT     = 1'b1
    } state_t;

    state_t                 state_q;
    logic [c_cnt_w-1:0]     byte_cnt_q;
    logic [c_idle_w-1:0]    idle_cnt_q;
    logic [B*N_BYTES-1:0]   word_q;
    logic                   valid_q;
    logic                   terr_q;

    // Head data is combinational, so the pop and the capture share one edge.
    assign fifo_rd     = ~reset & (state_q == ST_COLLECT) & ~fifo_empty & ~flush;
    assign word_data   = word_q;
    assign word_valid  = valid_q;
    assign timeout_err = terr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_COLLECT;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            if (flush) begin
                state_q    <= ST_COLLECT;
                byte_cnt_q <= '0;
                idle_cnt_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        if (fifo_rd) begin
                            for (int i = 0; i < N_BYTES; i++) begin
                                if (byte_cnt_q == c_cnt_w'(i)) begin
                                    word_q[i*B +: B] <= fifo_r_data;
                                end
                            end
                            idle_cnt_q <= '0;
                            if (byte_cnt_q == c_last_byte) begin
                                byte_cnt_q <= '0;
                                state_q    <= ST_OUT;
                                valid_q    <= 1'b1;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + c_cnt_one;
                            end
                        end else if ((byte_cnt_q != '0) && (TIMEOUT != 0)) begin
                            // Stale lanes are left in place; later pops overwrite them.
                            if (idle_cnt_q == c_idle_last) begin
                                byte_cnt_q <= '0;
                                idle_cnt_q <= '0;
                                terr_q     <= 1'b1;
                            end else begin
                                idle_cnt_q <= idle_cnt_q + c_idle_one;
                            end
                        end
                    end
                    ST_OUT: begin
                        if (word_ready) begin
                            valid_q <= 1'b0;
                            state_q <= ST_COLLECT;
                        end
                    end
                    default: state_q <= ST_COLLECT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_word_packer
//  Purpose  : Directed and random stimulus against a queue-based word model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_word_packer;

    localparam int B  = 8;
    localparam int NB = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [B-1:0]  fifo_r_data;
    logic          fifo_rd;
    logic          flush;
    logic [31:0]   word_data;
    logic          word_valid;
    logic          word_ready;
    logic          timeout_err;

    always #5 clk = ~clk;

    uart_rx_word_packer #(
        .B       (B),
        .N_BYTES (NB),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .flush       (flush),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .timeout_err (timeout_err)
    );

    logic [7:0]  fq[$];
    logic [7:0]  m_part[$];
    bit          m_out;
    int          m_idle;
    logic [31:0] m_word;
    bit          m_terr;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_count = 0;
    int terr_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = 1'b0;
        m_part.delete();
        m_idle = 0;
        m_terr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
    endtask

    // One clock: drive inputs, check the pop strobe, advance the model, check outputs.
    task automatic tick(input bit hold, input bit fl, input bit rdy);
        bit pop;
        fifo_empty  = hold || (fq.size() == 0);
        fifo_r_data = (fq.size() != 0) ? fq[0] : 8'h00;
        flush       = fl;
        word_ready  = rdy;
        #1;
        pop = !m_out && !fifo_empty && !fl;
        chk("fifo_rd", fifo_rd, pop);
        if (fifo_rd) rd_count++;
        @(posedge clk);
        m_terr = 1'b0;
        if (fl) begin
            m_part.delete();
            m_idle = 0;
            m_out  = 1'b0;
        end else if (m_out) begin
            if (rdy) m_out = 1'b0;
        end else if (pop) begin
            m_part.push_back(fq.pop_front());
            m_idle = 0;
            if (m_part.size() == NB) begin
                for (int i = 0; i < NB; i++) m_word[i*8 +: 8] = m_part[i];
                m_part.delete();
                m_out = 1'b1;
            end
        end else if (m_part.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_part.delete();
                m_idle = 0;
                m_terr = 1'b1;
            end
        end
        #1;
        chk("word_valid", word_valid, m_out);
        chk("timeout_err", timeout_err, m_terr);
        if (m_out) chk("word_data", word_data, m_word);
        if (timeout_err) terr_count++;
    endtask

    initial begin
        int hold_left;
        hold_left   = 0;
        reset       = 1'b1;
        fifo_empty  = 1'b1;
        fifo_r_data = 8'h00;
        flush       = 1'b0;
        word_ready  = 1'b0;
        model_reset();

        // Reset state, and no pop while reset is held even with data present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_data", word_data, 32'h0);
        chk("rst_terr", timeout_err, 1'b0);
        fifo_empty = 1'b0;
        #1;
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        fifo_empty = 1'b1;
        reset = 1'b0;

        // Back-to-back word
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd_count = 0;
        repeat (4) tick(0, 0, 1);
        chk("t1_valid", word_valid, 1'b1);
        chk("t1_data", word_data, 32'h44332211);
        chk("t1_rd_count", rd_count, 4);
        tick(0, 0, 1);

        // Backpressure holds the word and stops popping
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (4) tick(0, 0, 0);
        chk("t2_first", word_data, 32'h04030201);
        rd_count = 0;
        repeat (10) tick(0, 0, 0);
        chk("t2_no_rd", rd_count, 0);
        chk("t2_hold", word_data, 32'h04030201);
        repeat (5) tick(0, 0, 1);
        chk("t2_second_valid", word_valid, 1'b1);
        chk("t2_second", word_data, 32'h08070605);
        tick(0, 0, 1);

        // Timeout on the 16th idle cycle of a partial word
        push(8'hAA); push(8'hBB);
        repeat (2) tick(0, 0, 1);
        terr_count = 0;
        repeat (15) tick(0, 0, 1);
        chk("t3_no_early_terr", terr_count, 0);
        tick(0, 0, 1);
        chk("t3_terr", timeout_err, 1'b1);
        tick(0, 0, 1);
        chk("t3_terr_once", terr_count, 1);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        repeat (4) tick(0, 0, 1);
        chk("t3_clean_word", word_data, 32'h04030201);
        tick(0, 0, 1);

        // Flush drops a partial word
        terr_count = 0;
        push(8'h5A); push(8'h5B); push(8'h5C);
        repeat (3) tick(0, 0, 1);
        tick(0, 1, 1);
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        repeat (4) tick(0, 0, 1);
        chk("t4_valid", word_valid, 1'b1);
        chk("t4_data", word_data, 32'hC3C2C1C0);
        tick(0, 0, 1);
        chk("t4_no_terr", terr_count, 0);

        // Asynchronous reset between edges while a word is held
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        repeat (4) tick(0, 0, 0);
        chk("t5_pre_valid", word_valid, 1'b1);
        push(8'hE0); push(8'hE1);
        fifo_empty  = 1'b0;
        fifo_r_data = fq[0];
        reset = 1'b1;
        #2;
        model_reset();
        chk("t5_valid_drop", word_valid, 1'b0);
        chk("t5_rd_drop", fifo_rd, 1'b0);
        chk("t5_data_zero", word_data, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_rd_held", fifo_rd, 1'b0);
        reset = 1'b0;
        push(8'hE2); push(8'hE3);
        repeat (4) tick(0, 0, 1);
        chk("t5_after_word", word_data, 32'hE3E2E1E0);
        tick(0, 0, 1);

        // Long empty line with nothing collected
        rd_count   = 0;
        terr_count = 0;
        repeat (100) tick(0, 0, 1);
        chk("t6_no_rd", rd_count, 0);
        chk("t6_no_terr", terr_count, 0);

        // Random traffic, gaps, backpressure and occasional flush
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            if (hold_left > 0) hold_left--;
            else if ($urandom_range(0, 40) == 0) hold_left = $urandom_range(5, 25);
            tick(hold_left > 0, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
